// File: rtl/adc_line_pkg.sv
// Shared definitions for the ADC line assembler and the downstream zone-search stage.
// Word layout: {sample index, sample}.
package adc_line_pkg;

    localparam int PORTS      = 32;
    localparam int DATA_WIDTH = 16;
    localparam int IDX_WIDTH  = 5;
    localparam int WORD_WIDTH = IDX_WIDTH + DATA_WIDTH;

    typedef logic [WORD_WIDTH-1:0] line_word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1
    } line_state_t;

endpackage

// File: rtl/adc_line_assembler.sv
// Collects PORTS ADC samples into a shadow line and publishes it as an indexed word array.
// A holdoff timer rate-limits publication; lines that are interrupted or arrive too early are counted as drops.
module adc_line_assembler #(
    parameter int PORTS      = adc_line_pkg::PORTS,
    parameter int DATA_WIDTH = adc_line_pkg::DATA_WIDTH,
    parameter int MIN_GAP    = 40
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DATA_WIDTH-1:0]                               ADC_DATA,
    input  logic                                                ADC_DAV,
    input  logic                                                LINE_SYNC,
    output logic [PORTS-1:0][adc_line_pkg::IDX_WIDTH+DATA_WIDTH-1:0] ODATA,
    output logic                                                ODAV,
    output logic                                                LINE_ERR,
    output logic [7:0]                                          DROP_CNT
);
    import adc_line_pkg::*;

    localparam int            IW       = adc_line_pkg::IDX_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(PORTS - 1);
    localparam logic [7:0]    GAP_LOAD = 8'(MIN_GAP);

    line_state_t                         state_q, state_d;
    logic [IW-1:0]                       cnt_q, cnt_d;
    logic [7:0]                          hold_q;
    logic [PORTS-1:0][DATA_WIDTH-1:0]    shadow_q;

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          line_done;
    logic          line_err_d;
    logic          emit;
    logic          drop_evt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en      = 1'b0;
        wr_idx     = cnt_q;
        line_done  = 1'b0;
        line_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ADC_DAV && LINE_SYNC) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = IW'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (ADC_DAV && LINE_SYNC) begin
                    // A sync inside a line abandons it and restarts on this sample.
                    line_err_d = 1'b1;
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    cnt_d      = IW'(1);
                end else if (ADC_DAV) begin
                    wr_en  = 1'b1;
                    wr_idx = cnt_q;
                    if (cnt_q == LAST_IDX) begin
                        line_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign emit     = line_done && (hold_q == 8'd0);
    assign drop_evt = (line_done && (hold_q != 8'd0)) || line_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            shadow_q <= '0;
            ODATA    <= '0;
            ODAV     <= 1'b0;
            LINE_ERR <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ODAV     <= emit;
            LINE_ERR <= line_err_d;

            if (wr_en) begin
                shadow_q[wr_idx] <= ADC_DATA;
            end

            if (emit) begin
                hold_q <= GAP_LOAD;
            end else if (hold_q != 8'd0) begin
                hold_q <= hold_q - 8'd1;
            end

            // The final sample bypasses the shadow so the line publishes on its own edge.
            if (emit) begin
                for (int k = 0; k < PORTS; k++) begin
                    ODATA[k] <= {IW'(k), (k == PORTS - 1) ? ADC_DATA : shadow_q[k]};
                end
            end

            if (drop_evt && (DROP_CNT != 8'hFF)) begin
                DROP_CNT <= DROP_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_line_assembler.sv
// Randomized scoreboard bench for adc_line_assembler: a line-level model predicts publications,
// line errors and the drop count; a negedge monitor compares everything the DUT presents.
module tb_adc_line_assembler;

    localparam int NP  = 32;
    localparam int DW  = 16;
    localparam int WW  = 21;
    localparam int GAP = 40;

    typedef logic [NP-1:0][WW-1:0] line_t;
    typedef struct {
        int    cyc;
        line_t data;
    } emit_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic          adc_dav = 1'b0;
    logic          line_sync = 1'b0;
    line_t         odata;
    logic          odav;
    logic          line_err;
    logic [7:0]    drop_cnt;

    adc_line_assembler #(
        .PORTS      (NP),
        .DATA_WIDTH (DW),
        .MIN_GAP    (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ADC_DATA  (adc_data),
        .ADC_DAV   (adc_dav),
        .LINE_SYNC (line_sync),
        .ODATA     (odata),
        .ODAV      (odav),
        .LINE_ERR  (line_err),
        .DROP_CNT  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    emit_t         emit_q[$];
    int            err_q[$];
    logic [DW-1:0] line_q[$];
    bit            in_line  = 1'b0;
    int            drop_m   = 0;
    bit            emitted  = 1'b0;
    int            last_emit = 0;
    line_t         odata_m  = '0;

    function automatic void chk(bit ok, string name, string info);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, info);
        end
    endfunction

    // Line-level reference: a line is the 32 accepted samples following a sync;
    // it publishes only if more than GAP clocks have passed since the last publication.
    function automatic void model_step(bit dav, bit sync, logic [DW-1:0] d);
        line_t l;
        if (!dav) return;
        if (sync) begin
            if (in_line) begin
                err_q.push_back(edge_cnt);
                if (drop_m < 255) drop_m++;
            end
            line_q.delete();
            line_q.push_back(d);
            in_line = 1'b1;
        end else if (in_line) begin
            line_q.push_back(d);
            if (line_q.size() == NP) begin
                in_line = 1'b0;
                if (!emitted || (edge_cnt - last_emit > GAP)) begin
                    for (int k = 0; k < NP; k++) l[k] = {5'(k), line_q[k]};
                    odata_m = l;
                    emit_q.push_back('{edge_cnt, l});
                    emitted   = 1'b1;
                    last_emit = edge_cnt;
                end else if (drop_m < 255) begin
                    drop_m++;
                end
            end
        end
    endfunction

    task automatic cyc(bit dav, bit sync, logic [DW-1:0] d);
        adc_dav   = dav;
        line_sync = sync;
        adc_data  = d;
        @(posedge clk);
        edge_cnt++;
        model_step(dav, sync, d);
        @(negedge clk);
        adc_dav   = 1'b0;
        line_sync = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic noise_idle(int n);
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
    endtask

    // Full line of data base+k, with 'gap' empty clocks after each sample.
    task automatic send_line(int base, int gap);
        for (int k = 0; k < NP; k++) begin
            cyc(1'b1, k == 0, 16'(base + k));
            idle(gap);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (odav) begin
                if (emit_q.size() == 0) begin
                    chk(1'b0, "odav_unexpected", $sformatf("actual ODAV=1 at cycle %0d required 0", edge_cnt));
                end else begin
                    emit_t e;
                    e = emit_q.pop_front();
                    chk(e.cyc == edge_cnt, "odav_latency",
                        $sformatf("actual cycle %0d required %0d", edge_cnt, e.cyc));
                    chk(odata == e.data, "odav_data",
                        $sformatf("actual %h required %h", odata, e.data));
                end
            end else if (emit_q.size() > 0 && emit_q[0].cyc <= edge_cnt) begin
                chk(1'b0, "odav_missing", $sformatf("actual ODAV=0 at cycle %0d required 1", edge_cnt));
                void'(emit_q.pop_front());
            end

            if (line_err) begin
                if (err_q.size() == 0) begin
                    chk(1'b0, "line_err_unexpected", $sformatf("actual LINE_ERR=1 at cycle %0d required 0", edge_cnt));
                end else begin
                    int c;
                    c = err_q.pop_front();
                    chk(c == edge_cnt, "line_err_cycle", $sformatf("actual cycle %0d required %0d", edge_cnt, c));
                end
            end else if (err_q.size() > 0 && err_q[0] <= edge_cnt) begin
                chk(1'b0, "line_err_missing", $sformatf("actual LINE_ERR=0 at cycle %0d required 1", edge_cnt));
                void'(err_q.pop_front());
            end

            chk(drop_cnt == 8'(drop_m), "drop_cnt",
                $sformatf("actual %0d required %0d", drop_cnt, drop_m));
            chk(odata == odata_m, "odata_stable",
                $sformatf("actual %h required %h", odata, odata_m));
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk(odata == '0, "reset_odata", $sformatf("actual %h required 0", odata));
        chk(odav == 1'b0 && line_err == 1'b0, "reset_pulses",
            $sformatf("actual odav=%0b line_err=%0b required 0 0", odav, line_err));
        chk(drop_cnt == 8'd0, "reset_drop", $sformatf("actual %0d required 0", drop_cnt));
        rst = 1'b0;

        // Unsynced samples out of reset are ignored.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'($urandom));
        idle(3);

        // Dense line, then a sparse line with the same data after the holdoff expires.
        send_line(100, 0);
        idle(GAP + 5);
        send_line(100, 2);

        // Back-to-back line lands inside the holdoff and is dropped; a later one publishes.
        idle(GAP + 5);
        send_line(500, 0);
        send_line(900, 0);
        idle(GAP + 2);
        send_line(1300, 0);

        // Resync at sample 20, then a full line from the resynced sample.
        idle(GAP + 5);
        for (int k = 0; k < 20; k++) cyc(1'b1, k == 0, 16'(2000 + k));
        for (int k = 0; k < NP; k++) cyc(1'b1, k == 0, 16'(3000 + k));

        // Randomized lines with gaps, noise and occasional mid-line syncs.
        for (int l = 0; l < 15; l++) begin
            noise_idle($urandom_range(0, 50));
            cyc(1'b1, 1'b1, 16'($urandom));
            for (int k = 1; k < NP; k++) begin
                idle($urandom_range(0, 2));
                cyc(1'b1, ($urandom_range(0, 39) == 0), 16'($urandom));
            end
        end
        idle(GAP + 5);
        send_line(4000, 0);

        // Asynchronous reset in the middle of a line.
        for (int k = 0; k < 15; k++) cyc(1'b1, k == 0, 16'(5000 + k));
        #2;
        rst = 1'b1;
        in_line = 1'b0;
        line_q.delete();
        drop_m  = 0;
        emitted = 1'b0;
        odata_m = '0;
        #1;
        chk(odata == '0, "async_rst_odata", $sformatf("actual %h required 0", odata));
        chk(drop_cnt == 8'd0, "async_rst_drop", $sformatf("actual %0d required 0", drop_cnt));
        chk(odav == 1'b0 && line_err == 1'b0, "async_rst_pulses",
            $sformatf("actual odav=%0b line_err=%0b required 0 0", odav, line_err));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 15; k < 40; k++) cyc(1'b1, 1'b0, 16'(5000 + k));
        idle(2);
        send_line(6000, 1);

        // Many interrupted lines drive the drop counter into saturation.
        idle(GAP + 5);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b1, 16'($urandom));
            cyc(1'b1, 1'b0, 16'($urandom));
        end
        idle(3);
        chk(drop_cnt == 8'd255, "drop_saturate", $sformatf("actual %0d required 255", drop_cnt));

        idle(5);
        chk(emit_q.size() == 0, "emit_queue_drained",
            $sformatf("actual %0d pending required 0", emit_q.size()));
        chk(err_q.size() == 0, "err_queue_drained",
            $sformatf("actual %0d pending required 0", err_q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
